// File: rtl/lnk_seq_checker_pkg.sv
// Shared constants, FSM encoding and redundancy helper for the link sequence checker
// and the message producers that feed it.
package lnk_seq_checker_pkg;

  localparam int LNK_ASZ    = 6;
  localparam int LNK_DSZ    = 4;
  localparam int LNK_RSZ    = 4;
  localparam int LNK_CNT_SZ = 8;

  localparam logic [3:0] ERR_NONE = 4'd0;
  localparam logic [3:0] ERR_SRC  = 4'd1;
  localparam logic [3:0] ERR_DST  = 4'd2;
  localparam logic [3:0] ERR_RED  = 4'd3;
  localparam logic [3:0] ERR_SEQ  = 4'd4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CHECK = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Full-width sum; callers keep only the low RSZ bits.
  function automatic logic [15:0] red_sum(input logic [15:0] src,
                                          input logic [15:0] dst,
                                          input logic [15:0] dat);
    return src + dst + dat;
  endfunction

endpackage

// File: rtl/lnk_seq_checker_if.sv
// Two-phase req/ack message channel between a message FIFO and its sink.
interface lnk_seq_checker_if #(
  parameter int ASZ = 6,
  parameter int DSZ = 4,
  parameter int RSZ = 4
);
  logic           req;
  logic           ack;
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;

  modport master (output req, output src, output dst, output dat, output red, input ack);
  modport slave  (input req, input src, input dst, input dat, input red, output ack);
endinterface

// File: rtl/lnk_req_sync.sv
// Two-flop synchronizer for the incoming 2-phase request line.
module lnk_req_sync (
  input  logic i_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous request level.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/lnk_seq_checker.sv
// Terminal sink for 2-phase messages: checks address range, redundancy and data sequence,
// counts messages, latches the first error and drives the LED / two-digit debug display.
module lnk_seq_checker
  import lnk_seq_checker_pkg::*;
#(
  parameter int ASZ      = LNK_ASZ,
  parameter int DSZ      = LNK_DSZ,
  parameter int RSZ      = LNK_RSZ,
  parameter int MIN_ADDR = 0,
  parameter int MAX_ADDR = 55,
  parameter int CNT_SZ   = LNK_CNT_SZ
) (
  input  logic               i_clk,
  input  logic               reset,
  lnk_seq_checker_if.slave   rcv0,
  output logic               ready,
  output logic [3:0]         dbg_leds,
  output logic [3:0]         dbg_disp0,
  output logic [3:0]         dbg_disp1
);

  localparam logic [15:0] RED_MASK = 16'((32'd1 << RSZ) - 32'd1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic                req_s;
  logic                capture_s;
  logic                ack_step_s;
  logic                init_done_s;

  logic [ASZ-1:0]      src_r;
  logic [ASZ-1:0]      dst_r;
  logic [DSZ-1:0]      dat_r;
  logic [RSZ-1:0]      red_r;
  logic [DSZ-1:0]      prev_dat_r;
  logic [DSZ-1:0]      seq_exp_s;
  logic                first_r;
  logic                red_ok_s;
  logic [3:0]          code_s;
  logic [3:0]          chk_code_r;

  logic [CNT_SZ-1:0]   count_r;
  logic [CNT_SZ-1:0]   count_nxt_s;
  logic                ack_r;
  logic                ready_r;
  logic                run_r;
  logic                err_r;
  logic                wrap_r;
  logic                tgl_r;
  logic [3:0]          disp0_r;
  logic [3:0]          disp1_r;

  function automatic logic addr_ok(input logic [ASZ-1:0] a);
    return (int'(a) >= MIN_ADDR) && (int'(a) <= MAX_ADDR);
  endfunction

  lnk_req_sync u_req_sync (
    .i_clk (i_clk),
    .reset (reset),
    .d     (rcv0.req),
    .q     (req_s)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-state strobes; a pending message is req_s != ack.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    ack_step_s  = 1'b0;
    init_done_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        state_nxt_s = ST_IDLE;
        init_done_s = 1'b1;
      end
      ST_IDLE: begin
        if (req_s != ack_r) begin
          state_nxt_s = ST_CHECK;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CHECK: state_nxt_s = ST_ACK;
      ST_ACK: begin
        state_nxt_s = ST_IDLE;
        ack_step_s  = 1'b1;
      end
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Prioritised field check on the captured message.
  always_comb begin
    red_ok_s  = ((red_sum(16'(src_r), 16'(dst_r), 16'(dat_r)) ^ 16'(red_r)) & RED_MASK) == 16'd0;
    seq_exp_s = prev_dat_r + DSZ'(1);
    code_s    = ERR_NONE;
    if (!addr_ok(src_r)) begin
      code_s = ERR_SRC;
    end else if (!addr_ok(dst_r)) begin
      code_s = ERR_DST;
    end else if (!red_ok_s) begin
      code_s = ERR_RED;
    end else if (!first_r && (dat_r != seq_exp_s)) begin
      code_s = ERR_SEQ;
    end else begin
      code_s = ERR_NONE;
    end
  end

  assign count_nxt_s = count_r + CNT_SZ'(1);

  // Datapath: capture, check result, counters, error latch and display registers.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      src_r      <= {ASZ{1'b0}};
      dst_r      <= {ASZ{1'b0}};
      dat_r      <= {DSZ{1'b0}};
      red_r      <= {RSZ{1'b0}};
      prev_dat_r <= {DSZ{1'b0}};
      first_r    <= 1'b1;
      chk_code_r <= ERR_NONE;
      count_r    <= {CNT_SZ{1'b0}};
      ack_r      <= 1'b0;
      ready_r    <= 1'b0;
      run_r      <= 1'b0;
      err_r      <= 1'b0;
      wrap_r     <= 1'b0;
      tgl_r      <= 1'b0;
      disp0_r    <= 4'd0;
      disp1_r    <= 4'd0;
    end else begin
      if (init_done_s) begin
        ready_r <= 1'b1;
        run_r   <= ~err_r;
      end
      if (capture_s) begin
        src_r <= rcv0.src;
        dst_r <= rcv0.dst;
        dat_r <= rcv0.dat;
        red_r <= rcv0.red;
      end
      if (state_r == ST_CHECK) begin
        chk_code_r <= code_s;
      end
      if (ack_step_s) begin
        ack_r      <= ~ack_r;
        count_r    <= count_nxt_s;
        prev_dat_r <= dat_r;
        first_r    <= 1'b0;
        tgl_r      <= ~tgl_r;
        if (count_nxt_s == {CNT_SZ{1'b0}}) begin
          wrap_r <= 1'b1;
        end
        // Once an error is latched the display freezes on it until reset.
        if (!err_r) begin
          if (chk_code_r != ERR_NONE) begin
            err_r   <= 1'b1;
            run_r   <= 1'b0;
            disp0_r <= chk_code_r;
            disp1_r <= dat_r[3:0];
          end else begin
            disp0_r <= count_nxt_s[3:0];
            disp1_r <= dat_r[3:0];
          end
        end
      end
    end
  end

  assign rcv0.ack  = ack_r;
  assign ready     = ready_r;
  assign dbg_leds  = {tgl_r, wrap_r, err_r, run_r};
  assign dbg_disp0 = disp0_r;
  assign dbg_disp1 = disp1_r;

endmodule

// File: doc/lnk_seq_checker.md
Name: lnk_seq_checker

Overview:
- Terminal sink placed directly downstream of a message FIFO's send channel.
- Accepts 2-phase req/ack messages and checks each one: address range, redundancy field, and data sequence.
- Keeps a message count and latches the first error.
- Drives the 4-LED / two-digit debug display bundle (leds, disp0, disp1) that feeds the seven-segment path.

Parameters:
ASZ, 6, address field width (src, dst)
DSZ, 4, data field width
RSZ, 4, redundancy field width
MIN_ADDR, 0, lowest legal src/dst address
MAX_ADDR, 55, highest legal src/dst address
CNT_SZ, 8, message counter width

Ports:
i_clk  in  1  single clock for all logic
reset  in  1  asynchronous, active-high reset
rcv0_req  in  1  2-phase request; toggles once per message; may come from another clock domain
rcv0_ack  out  1  2-phase acknowledge
rcv0_src  in  ASZ  message source address; stable while rcv0_req != rcv0_ack
rcv0_dst  in  ASZ  message destination address; stable under the same rule
rcv0_dat  in  DSZ  payload; stable under the same rule
rcv0_red  in  RSZ  redundancy = (src + dst + dat) mod 2^RSZ
ready  out  1  high once the post-reset init is complete
dbg_leds  out  4  [0] running, [1] error latched, [2] counter wrapped, [3] toggles per message
dbg_disp0  out  4  no error: count[3:0]; error: error code
dbg_disp1  out  4  no error: last data[3:0]; error: offending data[3:0]

Behaviour:
- Reset (async assert, sync release):
  - rcv0_ack=0, ready=0, dbg_leds=0, dbg_disp0=0, dbg_disp1=0.
  - count=0, first-message flag set, state INIT.
- Req synchronizer: rcv0_req passes through 2 flops (req_s). A pending message is defined as req_s != rcv0_ack.
- FSM:
  - INIT: one cycle, then go to IDLE and set ready=1.
  - IDLE: if a message is pending, capture src, dst, dat, red into registers and go to CHECK.
  - CHECK: evaluate the captured fields, in this priority order:
    - src outside [MIN_ADDR, MAX_ADDR] -> code 1
    - dst outside the same range -> code 2
    - red mismatch (sum truncated to RSZ) -> code 3
    - first flag clear and dat != (prev_dat+1) mod 2^DSZ -> code 4
  - CHECK then always goes to ACK.
  - ACK:
    - Toggle rcv0_ack.
    - count += 1, wrapping mod 2^CNT_SZ; set dbg_leds[2] on the wrap to 0 (sticky).
    - prev_dat = dat; clear the first flag.
    - Toggle dbg_leds[3].
    - Return to IDLE.
- Latency: from a rcv0_req toggle to the rcv0_ack toggle is exactly 5 i_clk cycles (2 sync + IDLE + CHECK + ACK), with no back-pressure.
- Throughput: the next message cannot be detected until rcv0_ack has toggled and the producer toggles req again. One message is outstanding at most.
- Error latch:
  - Only the first error is stored: code, plus dat[3:0]. dbg_leds[1] becomes 1 and is sticky until reset.
  - Later errors are ignored, but messages are still acknowledged so the upstream never stalls.
  - The sequence check keeps tracking prev_dat after an error.
- dbg_leds[0] = ready & ~error.
- Display outputs are registered and update in the ACK cycle.
- Boundaries:
  - dat wrap from 2^DSZ-1 to 0 is legal sequence.
  - MIN_ADDR and MAX_ADDR themselves are legal.
  - If reset asserts mid-handshake, ack returns to 0 immediately. After release the checker treats req_s != 0 as pending. The upstream is reset together with this block.
  - A req toggle arriving during CHECK or ACK is held by the req!=ack comparison and is not lost.

Decomposition:
- Shared package/header:
  - error code constants (ERR_NONE=0, ERR_SRC=1, ERR_DST=2, ERR_RED=3, ERR_SEQ=4)
  - FSM state encodings (INIT, IDLE, CHECK, ACK)
  - redundancy-function macro, reused by the message producer
- Sub-module: lnk_req_sync (2-flop synchronizer with async reset). It is the only natural split; the FSM stays in the top module.

Test Plan:
- Reset release with no traffic -> ready=1 on the 2nd cycle after release; dbg_leds=4'b0001; ack=0.
- 20 valid messages (src=5, dst=23, dat=0..15 then 0..3, red correct) -> 20 ack toggles, each 5 cycles after its req; dbg_disp0=4 (count 20 low nibble); dbg_disp1=3; no error.
- Message with src=56 (MAX_ADDR+1) -> dbg_leds[1]=1, dbg_disp0=1, dbg_disp1=dat. Then a dst=60 message -> display unchanged (first error kept); both acked.
- Valid sequence 7, 8, then 10 -> code 4, dbg_disp1=10. A following 11 is accepted with no new latch.
- Red field off by one -> code 3. src=0, dst=55 at the bounds -> no error.
- Reset asserted 1 cycle after a req toggle -> ack=0 immediately. After release and the upstream reset, 3 clean messages -> count=3, no error.
- 256 messages -> dbg_leds[2]=1, count=0.
